// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit that owns Hi/Lo (one bit per cycle, 33-cycle latency).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU (latency 1).
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_wr_en,
    input  logic             lo_wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nxt;
    logic                 is_div;
    logic                 neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b, raw_a;
    logic [2*WIDTH-1:0]   acc;
    logic [4:0]           cnt;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    // Operand conditioning for the incoming request
    logic             in_signed, in_a_neg, in_b_neg;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;

    always_comb begin
        in_signed = ~op[0];
        in_a_neg  = in_signed & A[WIDTH-1];
        in_b_neg  = in_signed & B[WIDTH-1];
        in_mag_a  = in_a_neg ? -A : A;
        in_mag_b  = in_b_neg ? -B : B;
    end

    // Per-cycle step logic
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_part;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
        div_part = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
        div_ge   = div_part >= {1'b0, mag_b};
        // Partial remainder is always below 2*divisor, so the 32-bit difference is exact
        div_rem  = div_ge ? (div_part[WIDTH-1:0] - mag_b) : div_part[WIDTH-1:0];
        if (is_div)
            acc_step = {div_rem, acc[WIDTH-2:0], div_ge};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    // Sign fix-up applied in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod = neg_res ? -acc : acc;
        if (!is_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = raw_a;
            res_lo = '1;
        end else begin
            res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op[1] ? CALC : FIX;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
            raw_a   <= '0;
            acc     <= '0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= in_a_neg ^ in_b_neg;
                        neg_rem <= in_a_neg;
                        b_zero  <= (B == '0);
                        mag_a   <= in_mag_a;
                        mag_b   <= in_mag_b;
                        raw_a   <= A;
                        acc     <= '0;
                        cnt     <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1])
                            acc <= {{WIDTH{1'b0}}, in_mag_a} * {{WIDTH{1'b0}}, in_mag_b};
`endif
                    end else begin
                        if (hi_wr_en) hi_q <= wr_data;
                        if (lo_wr_en) lo_q <= wr_data;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    acc <= acc_step;
                    if (is_div)
                        mag_a <= {mag_a[WIDTH-2:0], 1'b0};
                    else
                        mag_b <= {1'b0, mag_b[WIDTH-1:1]};
                end
                FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: stimulus pushes expected Hi/Lo/latency, a monitor checks each done.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B, wr_data;
    logic        hi_wr_en, lo_wr_en;
    logic        busy, done;
    logic [31:0] hi, lo;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .hi_wr_en(hi_wr_en), .lo_wr_en(lo_wr_en), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          st;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic, MIPS divide-by-zero convention
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: r = sa * sb;
            2'd1: r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFFFFFF};
                else if (o == 2'd2) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end else
                    r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
        return o[1] ? 33 : 1;
`else
        return (o == 2'd0) ? 33 : 33;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 want no pending request (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("latency", 32'(cyc - e.st), 32'(e.lat));
                ref_hi = e.hi;
                ref_lo = e.lo;
            end
        end
    end

    // Called at a negedge with the DUT idle; start is sampled at the next posedge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] r;
        r     = model(o, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = latency(o);
        e.st  = cyc + 1;
        sbq.push_back(e);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d want idle", busy, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        hi_wr_en = h;
        lo_wr_en = l;
        wr_data  = d;
        @(negedge clk);
        hi_wr_en = 1'b0;
        lo_wr_en = 1'b0;
        if (h) ref_hi = d;
        if (l) ref_lo = d;
        chk("mt_hi", hi, ref_hi);
        chk("mt_lo", lo, ref_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          n;

        rst = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        wr_data = '0; hi_wr_en = 1'b0; lo_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'd0, 32'hFFFFFFFE, 32'd3);          wait_idle();
        issue(2'd1, 32'hFFFFFFFE, 32'd3);          wait_idle();
        issue(2'd2, 32'hFFFFFFF9, 32'd2);          wait_idle();
        issue(2'd3, 32'd7, 32'd2);                 wait_idle();
        issue(2'd2, 32'd5, 32'd0);                 wait_idle();
        issue(2'd2, 32'h80000000, 32'hFFFFFFFF);   wait_idle();
        issue(2'd2, 32'hFFFFFFF9, 32'd0);          wait_idle();

        mt(1'b1, 1'b0, 32'hDEADBEEF);
        mt(1'b0, 1'b1, 32'h0BADF00D);
        mt(1'b1, 1'b1, 32'h13579BDF);

        // MTLO while busy, then a stray start while busy
        issue(2'd3, 32'd1000, 32'd7);
        lo_wr_en = 1'b1; wr_data = 32'd1;
        @(negedge clk);
        lo_wr_en = 1'b0;
        chk("mtlo_busy_lo", lo, ref_lo);
        @(negedge clk);
        start = 1'b1; op = 2'd1; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // start and MTHI in the same idle cycle: start wins
        hi_wr_en = 1'b1; wr_data = 32'h12345678;
        issue(2'd2, 32'd100, 32'hFFFFFFFD);
        hi_wr_en = 1'b0;
        chk("start_beats_mt_hi", hi, ref_hi);
        wait_idle();

        // Back-to-back: second start in the done cycle
        issue(2'd3, 32'd123456, 32'd789);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
        issue(2'd3, 32'hFFFFFFFF, 32'd10);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            issue(ro, ra, rb);
            wait_idle();
        end

        // Reset mid-divide aborts at once
        issue(2'd2, 32'hFFFF0000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        sbq.delete();
        ref_hi = '0;
        ref_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(2'd1, 32'd6, 32'd7);
        wait_idle();
        chk("post_reset_lo", lo, 32'd42);
        chk("post_reset_hi", hi, 32'd0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
